// File: rtl/hazard_control_pkg.sv
// Shared hazard-unit defines: forwarding select, hazard FSM states,
// pipeline-control bundle and its canned values. Build option: HAZARD_PERF_EN.
package hazard_control_pkg;

   typedef enum logic [1:0] {
      FW_NONE,
      FW_EX_MEM,
      FW_MEM_WB
   } fw_sel_e;

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      FAULT
   } hz_state_e;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic ex_mem_write;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_bubble;
   } hz_ctrl_t;

   localparam hz_ctrl_t CTRL_RUN =
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam hz_ctrl_t CTRL_STALL =
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam hz_ctrl_t CTRL_BRANCH =
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam hz_ctrl_t CTRL_LOAD_USE =
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/hazard_control_if.sv
// Pipeline <-> hazard unit bundle. master: pipeline side, slave: hazard unit.
// Perf counter outputs exist only when HAZARD_PERF_EN is defined.
interface hazard_control_if;
   logic [4:0]  rs1_addr_ID;
   logic [4:0]  rs2_addr_ID;
   logic        rs1_used_ID;
   logic        rs2_used_ID;
   logic        MemRead_EX;
   logic        RegWrite_EX;
   logic [4:0]  rd_addr_EX;
   logic        branch_taken_EX;
   logic        dmem_req_MEM;
   logic        dmem_ready_MEM;
   logic        PCWrite;
   logic        IF_ID_Write;
   logic        ID_EX_Write;
   logic        EX_MEM_Write;
   logic        IF_ID_flush;
   logic        ID_EX_flush;
   logic        MEM_WB_bubble;
   logic        mem_timeout;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flushes;
   logic [31:0] perf_load_use;
`endif

   modport master (
      output rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID,
      output MemRead_EX, RegWrite_EX, rd_addr_EX, branch_taken_EX,
      output dmem_req_MEM, dmem_ready_MEM,
      input  PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
      input  IF_ID_flush, ID_EX_flush, MEM_WB_bubble, mem_timeout
`ifdef HAZARD_PERF_EN
      , input perf_stall_cycles, perf_flushes, perf_load_use
`endif
   );

   modport slave (
      input  rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID,
      input  MemRead_EX, RegWrite_EX, rd_addr_EX, branch_taken_EX,
      input  dmem_req_MEM, dmem_ready_MEM,
      output PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
      output IF_ID_flush, ID_EX_flush, MEM_WB_bubble, mem_timeout
`ifdef HAZARD_PERF_EN
      , output perf_stall_cycles, perf_flushes, perf_load_use
`endif
   );
endinterface

// File: rtl/hazard_control_stall_watchdog.sv
// Memory-wait watchdog counter. Ports: clk, rst_n, count (advance by one),
// clear (back to zero), expired (count reached LIMIT; never when LIMIT=0).
module stall_watchdog #(
   parameter int LIMIT = 255,
   parameter int CW    = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic count,
   input  logic clear,
   output logic expired
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (count)
         cnt <= cnt + 1'b1;
   end

   assign expired = (LIMIT > 0) && (cnt == CW'(LIMIT));

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard unit: load-use stall, branch flush, memory-wait freeze with
// timeout fault. Ports: clk, rst_n, hz (slave). Option: HAZARD_PERF_EN.
import hazard_control_pkg::*;

module hazard_control #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   hazard_control_if.slave  hz
);

   localparam int CW =
      (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam bit WD_ON = (MEM_TIMEOUT > 0);

   hz_state_e state;
   hz_ctrl_t  ctrl;
   logic      load_use;
   logic      mem_stall;
   logic      hold;
   logic      lu_stall;
   logic      wd_count;
   logic      wd_clear;
   logic      wd_expired;

   assign load_use = hz.MemRead_EX && hz.RegWrite_EX &&
                     (hz.rd_addr_EX != 5'd0) &&
                     ((hz.rs1_used_ID &&
                       (hz.rs1_addr_ID == hz.rd_addr_EX)) ||
                      (hz.rs2_used_ID &&
                       (hz.rs2_addr_ID == hz.rd_addr_EX)));

   assign mem_stall = hz.dmem_req_MEM && !hz.dmem_ready_MEM;

   // Counter sits at 0 in RUN, so the entry increment loads 1.
   assign wd_count =
      (state == RUN && mem_stall && WD_ON) ||
      (state == MEM_WAIT && !hz.dmem_ready_MEM && !wd_expired);
   assign wd_clear = (state == MEM_WAIT) && hz.dmem_ready_MEM;

   stall_watchdog #(
      .LIMIT (MEM_TIMEOUT),
      .CW    (CW)
   ) u_wd (
      .clk     (clk),
      .rst_n   (rst_n),
      .count   (wd_count),
      .clear   (wd_clear),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         unique case (state)
            RUN:
               if (mem_stall && WD_ON)
                  state <= MEM_WAIT;
            MEM_WAIT:
               if (hz.dmem_ready_MEM)
                  state <= RUN;
               else if (wd_expired)
                  state <= FAULT;
            FAULT:
               state <= FAULT;
            default:
               state <= RUN;
         endcase
      end
   end

   // While waiting, ready low freezes even if the request drops.
   assign hold = (state == FAULT) ||
                 (state == MEM_WAIT && !hz.dmem_ready_MEM) ||
                 (state == RUN && mem_stall);

   always_comb begin
      ctrl     = CTRL_RUN;
      lu_stall = 1'b0;
      if (rst_n) begin
         if (hold) begin
            ctrl = CTRL_STALL;
         end else if (hz.branch_taken_EX) begin
            ctrl = CTRL_BRANCH;
         end else if (load_use) begin
            ctrl     = CTRL_LOAD_USE;
            lu_stall = 1'b1;
         end
      end
   end

   assign hz.PCWrite       = ctrl.pc_write;
   assign hz.IF_ID_Write   = ctrl.if_id_write;
   assign hz.ID_EX_Write   = ctrl.id_ex_write;
   assign hz.EX_MEM_Write  = ctrl.ex_mem_write;
   assign hz.IF_ID_flush   = ctrl.if_id_flush;
   assign hz.ID_EX_flush   = ctrl.id_ex_flush;
   assign hz.MEM_WB_bubble = ctrl.mem_wb_bubble;
   assign hz.mem_timeout   = (state == FAULT);

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;
   logic [31:0] perf_lu;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall <= '0;
         perf_flush <= '0;
         perf_lu    <= '0;
      end else begin
         if (!ctrl.pc_write)
            perf_stall <= sat_inc(perf_stall);
         if (ctrl.if_id_flush)
            perf_flush <= sat_inc(perf_flush);
         if (lu_stall)
            perf_lu <= sat_inc(perf_lu);
      end
   end

   assign hz.perf_stall_cycles = perf_stall;
   assign hz.perf_flushes      = perf_flush;
   assign hz.perf_load_use     = perf_lu;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control (watchdog at 4 and disabled).
// Optional perf counters checked when HAZARD_PERF_EN is defined.
module tb_hazard_control;

   localparam int T = 4;

   // {PCWrite,IF_ID_Write,ID_EX_Write,EX_MEM_Write,
   //  IF_ID_flush,ID_EX_flush,MEM_WB_bubble,mem_timeout}
   localparam logic [7:0] P_RUN   = 8'b1111_0000;
   localparam logic [7:0] P_STALL = 8'b0000_0010;
   localparam logic [7:0] P_FAULT = 8'b0000_0011;
   localparam logic [7:0] P_BR    = 8'b1111_1100;
   localparam logic [7:0] P_LU    = 8'b0011_0100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   // reference model: memory wait length, fault flag, perf tallies
   int          m_len = 0;
   bit          m_fault = 1'b0;
   int unsigned c_stall = 0;
   int unsigned c_flush = 0;
   int unsigned c_lu = 0;

   always #5 clk = ~clk;

   hazard_control_if h ();
   hazard_control_if h0 ();

   hazard_control #(.MEM_TIMEOUT(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (h.slave)
   );

   hazard_control #(.MEM_TIMEOUT(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (h0.slave)
   );

   assign h0.rs1_addr_ID     = h.rs1_addr_ID;
   assign h0.rs2_addr_ID     = h.rs2_addr_ID;
   assign h0.rs1_used_ID     = h.rs1_used_ID;
   assign h0.rs2_used_ID     = h.rs2_used_ID;
   assign h0.MemRead_EX      = h.MemRead_EX;
   assign h0.RegWrite_EX     = h.RegWrite_EX;
   assign h0.rd_addr_EX      = h.rd_addr_EX;
   assign h0.branch_taken_EX = h.branch_taken_EX;
   assign h0.dmem_req_MEM    = h.dmem_req_MEM;
   assign h0.dmem_ready_MEM  = h.dmem_ready_MEM;

   wire [7:0] o = {h.PCWrite, h.IF_ID_Write, h.ID_EX_Write,
                   h.EX_MEM_Write, h.IF_ID_flush, h.ID_EX_flush,
                   h.MEM_WB_bubble, h.mem_timeout};
   wire [7:0] o0 = {h0.PCWrite, h0.IF_ID_Write, h0.ID_EX_Write,
                    h0.EX_MEM_Write, h0.IF_ID_flush, h0.ID_EX_flush,
                    h0.MEM_WB_bubble, h0.mem_timeout};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set(input int r1, input bit u1, input int r2,
                      input bit u2, input bit mr, input bit rw,
                      input int rd, input bit br, input bit req,
                      input bit rdy);
      h.rs1_addr_ID     = 5'(r1);
      h.rs1_used_ID     = u1;
      h.rs2_addr_ID     = 5'(r2);
      h.rs2_used_ID     = u2;
      h.MemRead_EX      = mr;
      h.RegWrite_EX     = rw;
      h.rd_addr_EX      = 5'(rd);
      h.branch_taken_EX = br;
      h.dmem_req_MEM    = req;
      h.dmem_ready_MEM  = rdy;
   endtask

   task automatic idle();
      set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // Priority when nothing freezes the pipe: branch, then load-use.
   function automatic logic [7:0] pick(input bit br, input bit lu);
      if (br)
         return P_BR;
      if (lu)
         return P_LU;
      return P_RUN;
   endfunction

   // Called just after a rising edge; checks mid-cycle, advances model.
   task automatic step(input string tag);
      logic [7:0] e;
      logic [7:0] e0;
      bit ms;
      bit lu;
      bit waiting;
      @(negedge clk);
      ms = h.dmem_req_MEM && !h.dmem_ready_MEM;
      lu = h.MemRead_EX && h.RegWrite_EX && (h.rd_addr_EX != 0) &&
           ((h.rs1_used_ID && h.rs1_addr_ID == h.rd_addr_EX) ||
            (h.rs2_used_ID && h.rs2_addr_ID == h.rd_addr_EX));
      waiting = (m_len > 0);
      if (!rst_n)
         e = P_RUN;
      else if (m_fault)
         e = P_FAULT;
      else if (waiting ? !h.dmem_ready_MEM : ms)
         e = P_STALL;
      else
         e = pick(h.branch_taken_EX, lu);
      e0 = !rst_n ? P_RUN : ms ? P_STALL : pick(h.branch_taken_EX, lu);
      chk(tag, 32'(o), 32'(e));
      chk({tag, "/wd_off"}, 32'(o0), 32'(e0));
      if (rst_n) begin
         c_stall += (e[7] == 1'b0) ? 1 : 0;
         c_flush += e[3] ? 1 : 0;
         c_lu    += (e == P_LU) ? 1 : 0;
         // m_len = cycles the unanswered access has been outstanding
         if (!m_fault) begin
            if (!waiting)
               m_len = ms ? 1 : 0;
            else if (h.dmem_ready_MEM)
               m_len = 0;
            else if (m_len >= T)
               m_fault = 1'b1;
            else
               m_len = m_len + 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic perf_chk(input string tag);
`ifdef HAZARD_PERF_EN
      chk({tag, "/perf_stall"}, h.perf_stall_cycles, c_stall);
      chk({tag, "/perf_flush"}, h.perf_flushes, c_flush);
      chk({tag, "/perf_lu"}, h.perf_load_use, c_lu);
`else
      if (tag.len() == 0)
         $display("perf counters not built");
`endif
   endtask

   // Called just after a rising edge; reset takes effect immediately.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "/async"}, 32'(o), 32'(P_RUN));
      chk({tag, "/async_wd_off"}, 32'(o0), 32'(P_RUN));
      m_len   = 0;
      m_fault = 1'b0;
      c_stall = 0;
      c_flush = 0;
      c_lu    = 0;
`ifdef HAZARD_PERF_EN
      chk({tag, "/perf_zero"}, h.perf_stall_cycles | h.perf_flushes |
          h.perf_load_use, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // reset held with a stalling memory on the inputs
      set(5, 1, 5, 1, 1, 1, 5, 1, 1, 0);
      @(posedge clk);
      #1;
      do_reset("reset");

      idle();
      step("idle");

      // load x5, add x6,x5,x1: exactly one stall cycle
      set(5, 1, 1, 1, 1, 1, 5, 0, 0, 1);
      step("lu_stall");
      set(5, 1, 1, 1, 0, 0, 0, 0, 0, 1);
      step("lu_after");

      // x0 and unused-operand cases never stall
      set(0, 1, 0, 1, 1, 1, 0, 0, 0, 1);
      step("lu_x0");
      set(5, 0, 3, 1, 1, 1, 5, 0, 0, 1);
      step("lu_unused");
      set(7, 0, 7, 1, 1, 1, 7, 0, 0, 0);
      step("lu_rs2");

      // branch wins over load-use
      set(5, 1, 1, 1, 1, 1, 5, 1, 0, 1);
      step("br_over_lu");

      // branch deferred by three memory-wait cycles
      set(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      step("mw_frz1");
      step("mw_frz2");
      step("mw_frz3");
      h.dmem_ready_MEM = 1'b1;
      step("mw_branch");
      idle();
      step("mw_idle");

      // watchdog: ready never arrives
      set(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i <= T; i++)
         step("to_wait");
      step("fault1");
      h.dmem_ready_MEM = 1'b1;
      step("fault_sticky");
      h.dmem_ready_MEM = 1'b0;
      do_reset("fault_rst");
      idle();
      step("post_rst");

      // two load-use stalls and one branch
      set(5, 1, 1, 1, 1, 1, 5, 0, 0, 1);
      step("pf_lu1");
      idle();
      step("pf_clr1");
      set(2, 0, 9, 1, 1, 1, 9, 0, 0, 1);
      step("pf_lu2");
      idle();
      step("pf_clr2");
      h.branch_taken_EX = 1'b1;
      step("pf_br");
      idle();
      step("pf_idle");
`ifdef HAZARD_PERF_EN
      chk("req37_stall", h.perf_stall_cycles, 32'd2);
      chk("req37_lu", h.perf_load_use, 32'd2);
      chk("req37_flush", h.perf_flushes, 32'd1);
`endif

      // random traffic with periodic resets
      do_reset("rand_start");
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 59) begin
            perf_chk("rand");
            do_reset("rand_rst");
         end
         set($urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 4) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
         step("rand");
      end
      perf_chk("rand_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum number of MEM_WAIT cycles before the timeout fault.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rs1_addr_ID, rs2_addr_ID  input  5 each  source register addresses of the instruction in ID.
REQ-005 rs1_used_ID, rs2_used_ID  input  1 each  the instruction in ID actually reads rs1 / rs2.
REQ-006 MemRead_EX, RegWrite_EX  input  1 each  the instruction in EX is a load / writes rd.
REQ-007 rd_addr_EX  input  5  destination register of the instruction in EX.
REQ-008 branch_taken_EX  input  1  the instruction in EX redirects the PC.
REQ-009 dmem_req_MEM, dmem_ready_MEM  input  1 each  data-memory request outstanding in MEM / memory completes this cycle.
REQ-010 PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write  output  1 each  the register updates when high and holds when low.
REQ-011 IF_ID_flush, ID_EX_flush, MEM_WB_bubble  output  1 each  the register loads a NOP.
REQ-012 mem_timeout  output  1  sticky fault flag.

Function
REQ-013 The FSM SHALL have states RUN, MEM_WAIT and FAULT, and all outputs SHALL be combinational from the state and the current inputs.
REQ-014 load_use SHALL equal MemRead_EX && RegWrite_EX && rd_addr_EX!=0 && ((rs1_used_ID && rs1_addr_ID==rd_addr_EX) || (rs2_used_ID && rs2_addr_ID==rd_addr_EX)).
REQ-015 mem_stall SHALL equal dmem_req_MEM && !dmem_ready_MEM.
REQ-016 Priority in RUN, highest first:
- mem_stall: all four *_Write SHALL be low, MEM_WB_bubble high, all flushes low.
- branch_taken_EX: IF_ID_flush=1, ID_EX_flush=1, all *_Write=1.
- load_use: PCWrite=0, IF_ID_Write=0, ID_EX_flush=1, EX_MEM_Write=1.
- otherwise: all *_Write=1 and all flushes/bubble=0.
REQ-017 A load-use stall SHALL last exactly one cycle; the bubble it inserts clears the condition, so no extra state is needed.
REQ-018 A branch deferred by mem_stall SHALL take effect in the first cycle mem_stall is low, because EX is frozen and branch_taken_EX stays high.
REQ-019 RUN SHALL move to MEM_WAIT when mem_stall=1 and MEM_TIMEOUT>0.
- The wait counter (width $clog2(MEM_TIMEOUT+1)) SHALL load 1 on that transition.
REQ-020 In MEM_WAIT:
- Outputs SHALL be as for mem_stall while dmem_ready_MEM=0.
- The counter SHALL increment each cycle.
- When dmem_ready_MEM=1, the FSM SHALL return to RUN, the counter SHALL clear, and outputs SHALL follow the REQ-016 evaluation without the mem_stall term.
REQ-021 When the counter equals MEM_TIMEOUT and dmem_ready_MEM=0, the FSM SHALL enter FAULT.
REQ-022 In FAULT:
- mem_timeout SHALL be 1.
- All *_Write SHALL be 0 and MEM_WB_bubble SHALL be 1.
- The FSM SHALL leave FAULT only on reset.
REQ-023 dmem_ready_MEM and the counter reaching MEM_TIMEOUT in the same cycle SHALL resolve to ready: the FSM returns to RUN with no fault.
REQ-024 MEM_TIMEOUT=0 SHALL disable the watchdog: the FSM stays in RUN and stalls on mem_stall indefinitely.
REQ-025 x0 SHALL never cause a load-use stall.

Reset
REQ-026 Asserting rst_n low SHALL asynchronously force state=RUN, counter=0 and mem_timeout=0.
- While rst_n is low, all *_Write SHALL be 1 and all flushes/bubble SHALL be 0.
REQ-027 Reset asserted mid-MEM_WAIT or in FAULT SHALL return the block to RUN on the next cycle after deassertion, with no residual stall.

Configuration
REQ-028 With HAZARD_PERF_EN defined, the block SHALL add these outputs, all zeroed by reset:
- perf_stall_cycles (32-bit): increments every cycle PCWrite=0.
- perf_flushes (32-bit): increments every cycle IF_ID_flush=1.
- perf_load_use (32-bit): increments every cycle load_use causes a stall.
- All three saturate at 32'hFFFFFFFF.
REQ-029 Without HAZARD_PERF_EN, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 hz_state_e (RUN, MEM_WAIT, FAULT) SHALL be added to the shared defines package alongside fw_sel_e.
REQ-031 The watchdog counter SHALL be a sub-module stall_watchdog (count, clear, expired), and the rest SHALL be inline logic.

Verification
REQ-032 Load x5 in EX with add x6,x5,x1 in ID (rs1_used=1) -> exactly one cycle with PCWrite=0, IF_ID_Write=0, ID_EX_flush=1, then all Write=1.
REQ-033 Load x0 in EX with rs1_addr_ID=0 -> no stall; the same case with rs1_used_ID=0 and a matching address -> no stall.
REQ-034 branch_taken_EX=1 together with load_use=1 -> IF_ID_flush=1, ID_EX_flush=1, PCWrite=1, and no stall.
REQ-035 dmem_req=1 with ready low for 3 cycles while branch_taken_EX=1 -> 3 frozen cycles with MEM_WB_bubble=1, then the flush on the cycle ready rises.
REQ-036 MEM_TIMEOUT=4 with ready never asserted -> FAULT after 4 MEM_WAIT cycles and mem_timeout=1; asserting rst_n low clears it.
REQ-037 With HAZARD_PERF_EN defined, 2 load-use stalls plus 1 branch -> perf_stall_cycles=2, perf_load_use=2, perf_flushes=1.
